// File: rtl/prga.sv
// RC4 keystream generator (PRGA) that decrypts a length-prefixed ciphertext
// buffer into a length-prefixed plaintext buffer, using an already-scheduled S box.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   en, rdy           start request, sampled only while rdy = 1 (idle)
//   s_addr, s_rddata  S permutation RAM address and read data
//   s_wrdata, s_wren  S permutation RAM write data and write enable
//   ct_addr           ciphertext RAM address
//   ct_rddata         ciphertext RAM read data; ct[0] = L, ct[1..L] = bytes
//   pt_addr           plaintext RAM address
//   pt_wrdata, pt_wren  plaintext RAM write data and write enable; same layout as ct
// All RAMs are synchronous: an address presented in cycle N gives data in cycle N+1.
module prga (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE,
        LEN_RD,
        LEN_WR,
        SI_RD,
        SI_CAP,
        SJ_RD,
        SJ_CAP,
        WR_I,
        WR_J,
        PAD_RD,
        PAD_CAP,
        PT_WR
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] i_q;
    logic [7:0] j_q;
    logic [7:0] k_q;
    logic [7:0] len_q;
    logic [7:0] si_q;
    logic [7:0] sj_q;
    logic [7:0] ctb_q;
    logic [7:0] pad_q;

    // Sequential state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i_q   <= 8'd0;
            j_q   <= 8'd0;
            k_q   <= 8'd0;
            len_q <= 8'd0;
            si_q  <= 8'd0;
            sj_q  <= 8'd0;
            ctb_q <= 8'd0;
            pad_q <= 8'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (en) begin
                        i_q <= 8'd0;
                        j_q <= 8'd0;
                        k_q <= 8'd1;
                    end
                end
                LEN_WR: begin
                    len_q <= ct_rddata;
                end
                SI_RD: begin
                    i_q <= i_q + 8'd1;
                end
                SI_CAP: begin
                    // s_rddata holds S[i] for the freshly incremented i
                    si_q <= s_rddata;
                    j_q  <= j_q + s_rddata;
                end
                SJ_CAP: begin
                    sj_q <= s_rddata;
                end
                PAD_RD: begin
                    // ct[k] was addressed during WR_J
                    ctb_q <= ct_rddata;
                end
                PAD_CAP: begin
                    pad_q <= s_rddata;
                end
                PT_WR: begin
                    if (k_q != len_q) begin
                        k_q <= k_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode; every output defaults to zero
    always_comb begin
        state_nx  = state;
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_nx = LEN_RD;
                end
            end
            LEN_RD: begin
                ct_addr  = 8'd0;
                state_nx = LEN_WR;
            end
            LEN_WR: begin
                // Length is copied straight from the read port into pt[0]
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                state_nx  = (ct_rddata == 8'd0) ? IDLE : SI_RD;
            end
            SI_RD: begin
                s_addr   = i_q + 8'd1;
                state_nx = SI_CAP;
            end
            SI_CAP: begin
                state_nx = SJ_RD;
            end
            SJ_RD: begin
                s_addr   = j_q;
                state_nx = SJ_CAP;
            end
            SJ_CAP: begin
                state_nx = WR_I;
            end
            WR_I: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_nx = WR_J;
            end
            WR_J: begin
                // When i == j this rewrites the same byte: S stays unchanged
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                ct_addr  = k_q;
                state_nx = PAD_RD;
            end
            PAD_RD: begin
                // After the swap S[i]+S[j] equals sj+si
                s_addr   = si_q + sj_q;
                state_nx = PAD_CAP;
            end
            PAD_CAP: begin
                state_nx = PT_WR;
            end
            PT_WR: begin
                pt_addr   = k_q;
                pt_wrdata = pad_q ^ ctb_q;
                pt_wren   = 1'b1;
                state_nx  = (k_q == len_q) ? IDLE : SI_RD;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: synchronous RAM models, an RC4 reference
// model in plain arithmetic, and one task per scenario.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    prga dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    always #5 clk = ~clk;

    // RAM contents and a bench-side load port
    logic [7:0] s_ram  [256];
    logic [7:0] ct_ram [256];
    logic [7:0] pt_ram [256];
    logic       ld_we = 1'b0;
    logic [1:0] ld_sel = 2'd0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;

    always @(posedge clk) begin
        s_rddata  <= s_ram[s_addr];
        ct_rddata <= ct_ram[ct_addr];
        if (s_wren) s_ram[s_addr] <= s_wrdata;
        if (pt_wren) pt_ram[pt_addr] <= pt_wrdata;
        if (ld_we) begin
            case (ld_sel)
                2'd0: s_ram[ld_addr] <= ld_data;
                2'd1: ct_ram[ld_addr] <= ld_data;
                default: pt_ram[ld_addr] <= ld_data;
            endcase
        end
    end

    int s_cnt = 0;
    int pt_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (s_wren) s_cnt <= s_cnt + 1;
        if (pt_wren) pt_cnt <= pt_cnt + 1;
        if (s_wren && pt_wren) both_cnt <= both_cnt + 1;
    end

    int checks = 0;
    int passed = 0;

    // Reference state
    logic [7:0] ms     [256];
    logic [7:0] s_save [256];
    logic [7:0] ct_m   [256];
    logic [7:0] exp_pt [256];

    task automatic model_run();
        int i, j, t, len;
        i = 0;
        j = 0;
        len = int'(ct_m[0]);
        exp_pt[0] = ct_m[0];
        for (int k = 1; k <= len; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(ms[i])) % 256;
            t = int'(ms[i]);
            ms[i] = ms[j];
            ms[j] = 8'(t);
            exp_pt[k] = ms[(int'(ms[i]) + int'(ms[j])) % 256] ^ ct_m[k];
        end
    endtask

    task automatic ld_write(input logic [1:0] sel, input logic [7:0] a,
                            input logic [7:0] d);
        @(negedge clk);
        ld_we = 1'b1;
        ld_sel = sel;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_we = 1'b0;
    endtask

    task automatic load_s();
        for (int a = 0; a < 256; a++) ld_write(2'd0, 8'(a), ms[a]);
    endtask

    task automatic load_ct();
        for (int a = 0; a <= int'(ct_m[0]); a++) ld_write(2'd1, 8'(a), ct_m[a]);
    endtask

    task automatic fill_pt(input logic [7:0] v);
        for (int a = 0; a < 256; a++) ld_write(2'd2, 8'(a), v);
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) ms[a] = 8'(a);
    endtask

    task automatic set_random_perm();
        int r;
        logic [7:0] t;
        set_identity();
        for (int a = 255; a > 0; a--) begin
            r = int'($urandom_range(a, 0));
            t = ms[a];
            ms[a] = ms[r];
            ms[r] = t;
        end
    endtask

    task automatic set_random_ct(input int len);
        ct_m[0] = 8'(len);
        for (int a = 1; a < 256; a++) ct_m[a] = 8'($urandom);
    endtask

    // Pulse (or toggle) en; count rising edges from the accepting one until rdy
    task automatic run(input bit toggle, output int cycles, output logic first_rdy);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        cycles = 1;
        first_rdy = rdy;
        en = 1'b0;
        while (!rdy && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (toggle) en = ~en;
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy);
        else passed++;
        checks++;
        if ({s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren} !== 42'd0)
            $display("FAIL reset_outs: got %h want 0",
                     {s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren});
        else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy, s_wren, pt_wren, s_addr, ct_addr, pt_addr} !== {1'b1, 26'd0})
            $display("FAIL idle_outs: got %h want %h",
                     {rdy, s_wren, pt_wren, s_addr, ct_addr, pt_addr}, {1'b1, 26'd0});
        else passed++;
    endtask

    task automatic test_basic_vector();
        int cyc;
        logic fr;
        logic [7:0] want [4];
        want = '{8'h03, 8'h02, 8'h05, 8'h07};
        set_identity();
        load_s();
        ct_m[0] = 8'h03; ct_m[1] = 8'h00; ct_m[2] = 8'h00; ct_m[3] = 8'h00;
        load_ct();
        fill_pt(8'h5A);
        run(1'b0, cyc, fr);
        checks++;
        if (fr !== 1'b0) $display("FAIL basic_rdy_drop: got %b want 0", fr);
        else passed++;
        checks++;
        if (cyc != 30) $display("FAIL basic_cycles: got %0d want 30", cyc);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pt_ram[k] !== want[k])
                $display("FAIL basic_pt[%0d]: got %h want %h", k, pt_ram[k], want[k]);
            else passed++;
        end
        checks++;
        if ({s_ram[2], s_ram[3], s_ram[5]} !== 24'h030502)
            $display("FAIL basic_s235: got %h want 030502",
                     {s_ram[2], s_ram[3], s_ram[5]});
        else passed++;
    endtask

    task automatic test_zero_len();
        int cyc, s0, p0;
        logic fr;
        ct_m[0] = 8'h00;
        load_ct();
        fill_pt(8'h5A);
        s0 = s_cnt;
        p0 = pt_cnt;
        run(1'b0, cyc, fr);
        @(negedge clk);
        checks++;
        if (cyc != 3) $display("FAIL zero_cycles: got %0d want 3", cyc);
        else passed++;
        checks++;
        if (s_cnt - s0 != 0) $display("FAIL zero_s_wren: got %0d want 0", s_cnt - s0);
        else passed++;
        checks++;
        if (pt_cnt - p0 != 1) $display("FAIL zero_pt_wren: got %0d want 1", pt_cnt - p0);
        else passed++;
        checks++;
        if ({pt_ram[0], pt_ram[1]} !== 16'h005A)
            $display("FAIL zero_pt: got %h want 005a", {pt_ram[0], pt_ram[1]});
        else passed++;
    endtask

    task automatic test_self_swap();
        int cyc;
        logic fr;
        int bad;
        set_identity();
        load_s();
        ct_m[0] = 8'h01;
        ct_m[1] = 8'hAA;
        load_ct();
        run(1'b0, cyc, fr);
        checks++;
        if ({pt_ram[0], pt_ram[1]} !== 16'h01A8)
            $display("FAIL self_swap_pt: got %h want 01a8", {pt_ram[0], pt_ram[1]});
        else passed++;
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_ram[a] !== 8'(a)) bad++;
        checks++;
        if (bad != 0) $display("FAIL self_swap_s: got %0d changed want 0", bad);
        else passed++;
        checks++;
        if (cyc != 12) $display("FAIL self_swap_cycles: got %0d want 12", cyc);
        else passed++;
    endtask

    // Scenario: fresh S and ct, run, then compare pt[0..L], S and timing
    task automatic test_run_vs_model(input string name, input bit keysched,
                                     input int len, input bit toggle);
        int cyc, j, t;
        logic fr;
        logic [7:0] key [3];
        if (keysched) begin
            for (int a = 0; a < 3; a++) key[a] = 8'($urandom);
            set_identity();
            j = 0;
            for (int a = 0; a < 256; a++) begin
                j = (j + int'(ms[a]) + int'(key[a % 3])) % 256;
                t = int'(ms[a]);
                ms[a] = ms[j];
                ms[j] = 8'(t);
            end
        end else begin
            set_random_perm();
        end
        set_random_ct(len);
        load_s();
        load_ct();
        model_run();
        run(toggle, cyc, fr);
        checks++;
        if (cyc != 3 + 9 * len)
            $display("FAIL %s_cycles: got %0d want %0d", name, cyc, 3 + 9 * len);
        else passed++;
        for (int k = 0; k <= len; k++) begin
            checks++;
            if (pt_ram[k] !== exp_pt[k])
                $display("FAIL %s_pt[%0d]: got %h want %h", name, k, pt_ram[k], exp_pt[k]);
            else passed++;
        end
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (s_ram[a] !== ms[a])
                $display("FAIL %s_s[%0d]: got %h want %h", name, a, s_ram[a], ms[a]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, n, guard, sc, pc;
        logic fr;
        set_random_perm();
        s_save = ms;
        set_random_ct(6);
        load_s();
        load_ct();
        fill_pt(8'hEE);
        model_run();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        n = 0;
        guard = 0;
        while (n < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (s_wren) n++;
        end
        checks++;
        if (n != 4) $display("FAIL abort_reach_wr_j: got %0d want 4", n);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy, s_wren, pt_wren} !== 3'b100)
            $display("FAIL abort_outs: got %b want 100", {rdy, s_wren, pt_wren});
        else passed++;
        sc = s_cnt;
        pc = pt_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (s_cnt != sc || pt_cnt != pc)
            $display("FAIL abort_no_writes: got %0d want 0", (s_cnt - sc) + (pt_cnt - pc));
        else passed++;
        checks++;
        if ({pt_ram[0], pt_ram[1], pt_ram[2]} !== {8'd6, exp_pt[1], 8'hEE})
            $display("FAIL abort_pt: got %h want %h",
                     {pt_ram[0], pt_ram[1], pt_ram[2]}, {8'd6, exp_pt[1], 8'hEE});
        else passed++;
        rst_n = 1'b1;
        ms = s_save;
        load_s();
        model_run();
        run(1'b0, cyc, fr);
        checks++;
        if (cyc != 57) $display("FAIL restart_cycles: got %0d want 57", cyc);
        else passed++;
        for (int k = 0; k <= 6; k++) begin
            checks++;
            if (pt_ram[k] !== exp_pt[k])
                $display("FAIL restart_pt[%0d]: got %h want %h", k, pt_ram[k], exp_pt[k]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc, ones;
        set_random_perm();
        set_random_ct(4);
        load_s();
        load_ct();
        model_run();
        model_run();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        while (!rdy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 39) $display("FAIL b2b_first_cycles: got %0d want 39", cyc);
        else passed++;
        @(posedge clk);
        #1;
        en = 1'b0;
        checks++;
        if (rdy !== 1'b0) $display("FAIL b2b_restart: got rdy %b want 0", rdy);
        else passed++;
        ones = 1;
        while (!rdy && ones < 200) begin
            @(posedge clk);
            #1;
            ones++;
        end
        checks++;
        if (ones != 39) $display("FAIL b2b_second_cycles: got %0d want 39", ones);
        else passed++;
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if (pt_ram[k] !== exp_pt[k])
                $display("FAIL b2b_pt[%0d]: got %h want %h", k, pt_ram[k], exp_pt[k]);
            else passed++;
        end
        checks++;
        if (s_ram[1] !== ms[1] || s_ram[2] !== ms[2] || s_ram[ms[1]] !== ms[ms[1]])
            $display("FAIL b2b_s: got %h%h want %h%h", s_ram[1], s_ram[2], ms[1], ms[2]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_vector();
        test_zero_len();
        test_self_swap();
        test_run_vs_model("keysched", 1'b1, 255, 1'b0);
        for (int r = 0; r < 3; r++)
            test_run_vs_model("random", 1'b0, int'($urandom_range(40, 1)), 1'b0);
        test_run_vs_model("toggle_en", 1'b0, 20, 1'b1);
        test_reset_mid_run();
        test_back_to_back();
        @(negedge clk);
        checks++;
        if (both_cnt != 0) $display("FAIL wren_overlap: got %0d want 0", both_cnt);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
